// File: rtl/mux_pkg.sv
// Shared constants for the N:1 scanning multiplexer: mode encodings and an
// elaboration-time log2 helper used to validate the select width.
package mux_pkg;

    localparam logic MODE_MANUAL = 1'b0;
    localparam logic MODE_SCAN   = 1'b1;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value)
            result++;
        return result;
    endfunction

endpackage

// File: rtl/mux_nx1_scan_if.sv
// Bus bundle between a multi-channel source/controller and the scanning mux.
// The master drives channel data and select controls; the slave returns the muxed lane.
interface mux_nx1_scan_if #(
    parameter int N       = 4,
    parameter int W       = 1,
    parameter int SELW    = 2,
    parameter int DWELL_W = 8
);
    logic [N*W-1:0]     in_data;
    logic [SELW-1:0]    sel;
    logic               sel_valid;
    logic               mode;
    logic [DWELL_W-1:0] dwell;
    logic [W-1:0]       y;
    logic               y_valid;
    logic [SELW-1:0]    cur_sel;
    logic               sel_err;
    logic               wrap;

    modport master (
        output in_data, sel, sel_valid, mode, dwell,
        input  y, y_valid, cur_sel, sel_err, wrap
    );

    modport slave (
        input  in_data, sel, sel_valid, mode, dwell,
        output y, y_valid, cur_sel, sel_err, wrap
    );
endinterface

// File: rtl/mux_scan_ctrl.sv
// Select controller: manual range-checked load or auto-scan with a live dwell compare,
// plus the one-cycle sel_err / wrap pulses.
module mux_scan_ctrl
    import mux_pkg::*;
#(
    parameter int N       = 4,
    parameter int SELW    = 2,
    parameter int DWELL_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [SELW-1:0]    i_sel,
    input  logic               i_sel_valid,
    input  logic               i_mode,
    input  logic [DWELL_W-1:0] i_dwell,
    output logic [SELW-1:0]    o_cur_sel,
    output logic               o_sel_err,
    output logic               o_wrap
);
    // One extra bit so N == 2**SELW is representable in the range compare.
    localparam logic [SELW:0]     N_LIM    = (SELW+1)'(N);
    localparam logic [SELW-1:0]   LAST_SEL = SELW'(N - 1);

    logic [SELW-1:0]    r_sel;
    logic [DWELL_W-1:0] r_cnt;
    logic               r_sel_err;
    logic               r_wrap;
    logic               w_in_range;
    logic               w_at_last;

    assign w_in_range = ({1'b0, i_sel} < N_LIM);
    assign w_at_last  = (r_sel == LAST_SEL);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sel     <= '0;
            r_cnt     <= '0;
            r_sel_err <= 1'b0;
            r_wrap    <= 1'b0;
        end else begin
            r_sel_err <= 1'b0;
            r_wrap    <= 1'b0;
            if (i_mode == MODE_SCAN) begin
                // >= rather than == so a dwell lowered below the count advances at once.
                if (r_cnt >= i_dwell) begin
                    r_cnt  <= '0;
                    r_sel  <= w_at_last ? '0 : r_sel + SELW'(1);
                    r_wrap <= w_at_last;
                end else begin
                    r_cnt <= r_cnt + DWELL_W'(1);
                end
            end else begin
                r_cnt <= '0;
                if (i_sel_valid) begin
                    if (w_in_range)
                        r_sel <= i_sel;
                    else
                        r_sel_err <= 1'b1;
                end
            end
        end
    end

    assign o_cur_sel = r_sel;
    assign o_sel_err = r_sel_err;
    assign o_wrap    = r_wrap;

endmodule

// File: rtl/mux_nx1_scan.sv
// N:1, W-bit multiplexer with registered select and output; the selected lane is
// registered one cycle behind cur_sel.
module mux_nx1_scan
    import mux_pkg::*;
#(
    parameter int N       = 4,
    parameter int W       = 1,
    parameter int SELW    = 2,
    parameter int DWELL_W = 8
) (
    input  logic          clk,
    input  logic          rst,
    mux_nx1_scan_if.slave bus
);
    if (SELW < clog2(N) || N < 2) begin : g_param_check
        $error("mux_nx1_scan: need N >= 2 and 2**SELW >= N (N=%0d SELW=%0d)", N, SELW);
    end

    logic [SELW-1:0] w_cur_sel;
    logic [W-1:0]    w_y;
    logic [W-1:0]    r_y;
    logic            r_y_valid;

    mux_scan_ctrl #(
        .N       (N),
        .SELW    (SELW),
        .DWELL_W (DWELL_W)
    ) u_ctrl (
        .clk         (clk),
        .rst         (rst),
        .i_sel       (bus.sel),
        .i_sel_valid (bus.sel_valid),
        .i_mode      (bus.mode),
        .i_dwell     (bus.dwell),
        .o_cur_sel   (w_cur_sel),
        .o_sel_err   (bus.sel_err),
        .o_wrap      (bus.wrap)
    );

    // Explicit compare loop: a select with no matching channel yields 0, never X.
    always_comb begin
        w_y = '0;
        for (int k = 0; k < N; k++) begin
            if (w_cur_sel == SELW'(k))
                w_y = bus.in_data[k*W +: W];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_y       <= '0;
            r_y_valid <= 1'b0;
        end else begin
            r_y       <= w_y;
            r_y_valid <= 1'b1;
        end
    end

    assign bus.y       = r_y;
    assign bus.y_valid = r_y_valid;
    assign bus.cur_sel = w_cur_sel;

endmodule
